data_cache_responder: RTL and testbench

- Direct-mapped, write-through, read-allocate data cache; the responder end of the load/store unit's cache request interface.
- Serves load reads combinationally on a hit; refills from the memory bus on a miss.
- Forwards every store to memory and updates the line in place on a store hit.
- Sits between the load/store execution unit and the memory bus arbiter.

---
 rtl/data_cache_responder.sv | 136 +++++++++++++
 tb/tb_data_cache_responder.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/data_cache_responder.sv
// Direct-mapped, write-through, read-allocate data cache with one 32-bit word per line.
// Read hits are answered combinationally; misses refill from memory and every store is forwarded.
module data_cache_responder #(
    parameter  int SETS    = 16,
    localparam int INDEX_W = $clog2(SETS)
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] cache_address,
    input  logic        cache_read,
    input  logic        cache_write,
    inout  wire  [31:0] cache_data,
    output logic        cache_hit,
    output logic [31:0] mem_address,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] mem_data_out,
    input  logic [31:0] mem_data_in,
    input  logic        mem_ready
);

    localparam int TAG_W = 32 - INDEX_W - 2;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        STORE
    } state_t;

    state_t state, state_next;

    logic [SETS-1:0]    valid;
    logic [TAG_W-1:0]   tags  [SETS];
    logic [31:0]        lines [SETS];

    logic [INDEX_W-1:0] req_index;
    logic [TAG_W-1:0]   req_tag;
    logic [INDEX_W-1:0] mem_index;
    logic [TAG_W-1:0]   mem_tag;
    logic               lookup_hit;
    logic               drive_data;
    logic               start_store;
    logic               start_fetch;
    logic               refill;
    logic               store_update;
    logic [1:0]         unused_addr_bits;

    assign req_index        = cache_address[INDEX_W+1:2];
    assign req_tag          = cache_address[31:INDEX_W+2];
    assign mem_index        = mem_address[INDEX_W+1:2];
    assign mem_tag          = mem_address[31:INDEX_W+2];
    assign unused_addr_bits = cache_address[1:0];

    assign lookup_hit   = valid[req_index] && (tags[req_index] == req_tag);
    assign refill       = (state == FETCH) && mem_ready;
    // The store updates the line using the latched bus address, not the live request.
    assign store_update = (state == STORE) && mem_ready && valid[mem_index]
                          && (tags[mem_index] == mem_tag);

    assign cache_data = drive_data ? lines[req_index] : 'z;

    // NOTE: every output of this block is given a default first so no path infers a latch.
    always_comb begin
        state_next  = state;
        cache_hit   = 1'b0;
        drive_data  = 1'b0;
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        start_store = 1'b0;
        start_fetch = 1'b0;
        case (state)
            IDLE: begin
                if (cache_write) begin
                    start_store = 1'b1;
                    state_next  = STORE;
                end else if (cache_read) begin
                    if (lookup_hit) begin
                        cache_hit  = 1'b1;
                        drive_data = 1'b1;
                    end else begin
                        start_fetch = 1'b1;
                        state_next  = FETCH;
                    end
                end
            end
            FETCH: begin
                mem_read = 1'b1;
                if (mem_ready) state_next = IDLE;
            end
            STORE: begin
                mem_write = 1'b1;
                if (mem_ready) begin
                    cache_hit  = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            mem_address  <= '0;
            mem_data_out <= '0;
        end else begin
            state <= state_next;
            if (start_store) begin
                mem_address  <= {cache_address[31:2], 2'b00};
                mem_data_out <= cache_data;
            end else if (start_fetch) begin
                mem_address  <= {cache_address[31:2], 2'b00};
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid <= '0;
        end else if (refill) begin
            valid[mem_index] <= 1'b1;
        end
    end

    // NOTE: tag and data storage has no reset; the valid bits alone decide whether a line is usable.
    always_ff @(posedge clk) begin
        if (refill) begin
            lines[mem_index] <= mem_data_in;
            tags[mem_index]  <= mem_tag;
        end else if (store_update) begin
            lines[mem_index] <= mem_data_out;
        end
    end

endmodule

// File: tb/tb_data_cache_responder.sv
// Bench for data_cache_responder: a memory model answers the bus, and read data is
// checked through a queue of expected values popped whenever a read hit appears.
module tb_data_cache_responder;

    typedef struct {
        logic [31:0] addr;
        logic        wr;
        logic [31:0] wdata;
        int          lat;
        logic        miss;
        logic [31:0] rdata;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] cache_address;
    logic        cache_read;
    logic        cache_write;
    wire  [31:0] cache_data;
    logic        cache_hit;
    logic [31:0] mem_address;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_data_out;
    logic [31:0] mem_data_in;
    logic        mem_ready;

    logic        drive_en;
    logic [31:0] drive_val;

    int errors = 0;
    int checks = 0;
    logic [31:0] exp_q[$];
    logic [31:0] mem_model [logic [31:0]];
    vec_t        vecs [12];

    assign cache_data = drive_en ? drive_val : 'z;

    always #5 clk = ~clk;

    data_cache_responder #(.SETS(16)) dut (
        .clk          (clk),
        .reset        (reset),
        .cache_address(cache_address),
        .cache_read   (cache_read),
        .cache_write  (cache_write),
        .cache_data   (cache_data),
        .cache_hit    (cache_hit),
        .mem_address  (mem_address),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .mem_data_out (mem_data_out),
        .mem_data_in  (mem_data_in),
        .mem_ready    (mem_ready)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] mem_value(input logic [31:0] a);
        if (mem_model.exists(a)) return mem_model[a];
        return ~a;
    endfunction

    // Runs the bus until cache_hit, serving memory requests after lat busy cycles.
    task automatic run_until_hit(input int lat, input logic [31:0] exp_addr,
                                 input logic is_wr, input logic [31:0] exp_wdata,
                                 output int cyc, output int rd, output int wr);
        int  busy;
        bit  done;
        cyc = 0; rd = 0; wr = 0; busy = 0; done = 0;
        while (!done) begin
            @(negedge clk);
            cyc++;
            if (mem_read) begin
                rd++;
                check("mem_address during fetch", mem_address, exp_addr);
            end
            if (mem_write) begin
                wr++;
                check("mem_address during store", mem_address, exp_addr);
                if (is_wr) check("mem_data_out during store", mem_data_out, exp_wdata);
            end
            if (cache_hit) begin
                done = 1;
                if (cache_read && !cache_write) begin
                    if (exp_q.size() == 0) check("unexpected read hit", 32'd1, 32'd0);
                    else check("read data", cache_data, exp_q.pop_front());
                end
            end else if (cyc >= 60) begin
                check("timeout waiting for cache_hit", 32'd0, 32'd1);
                done = 1;
            end
            @(posedge clk);
            #1;
            if (!done && (mem_read || mem_write)) begin
                busy++;
                mem_ready = (busy == lat);
                if (mem_ready && mem_write) mem_model[mem_address] = mem_data_out;
                mem_data_in = (mem_ready && mem_read) ? mem_value(mem_address) : 32'hBAD0_BAD0;
            end else begin
                mem_ready   = 1'b0;
                mem_data_in = 32'hBAD0_BAD0;
            end
        end
    endtask

    task automatic do_req(input int id, input vec_t v);
        int cyc, rd, wr;
        logic [31:0] aligned;
        aligned       = {v.addr[31:2], 2'b00};
        cache_address = v.addr;
        cache_read    = !v.wr;
        cache_write   = v.wr;
        drive_en      = v.wr;
        drive_val     = v.wdata;
        if (!v.wr) exp_q.push_back(v.rdata);
        run_until_hit(v.lat, aligned, v.wr, v.wdata, cyc, rd, wr);
        cache_read  = 1'b0;
        cache_write = 1'b0;
        drive_en    = 1'b0;
        if (v.wr) begin
            check($sformatf("vec%0d store cycles", id), cyc, v.lat + 1);
            check($sformatf("vec%0d store mem_write cycles", id), wr, v.lat);
            check($sformatf("vec%0d store mem_read cycles", id), rd, 0);
        end else begin
            check($sformatf("vec%0d read cycles", id), cyc, v.miss ? v.lat + 2 : 1);
            check($sformatf("vec%0d mem_read cycles", id), rd, v.miss ? v.lat : 0);
            check($sformatf("vec%0d mem_write cycles", id), wr, 0);
        end
    endtask

    initial begin
        int cyc, rd, wr;

        vecs[0]  = '{addr: 32'h0000_0040, wr: 1'b0, wdata: 32'h0,           lat: 3, miss: 1'b1, rdata: 32'hDEAD_BEEF};
        vecs[1]  = '{addr: 32'h0000_0040, wr: 1'b0, wdata: 32'h0,           lat: 1, miss: 1'b0, rdata: 32'hDEAD_BEEF};
        vecs[2]  = '{addr: 32'h0000_0040, wr: 1'b1, wdata: 32'h1234_5678,   lat: 2, miss: 1'b0, rdata: 32'h0};
        vecs[3]  = '{addr: 32'h0000_0040, wr: 1'b0, wdata: 32'h0,           lat: 1, miss: 1'b0, rdata: 32'h1234_5678};
        vecs[4]  = '{addr: 32'h0000_0440, wr: 1'b0, wdata: 32'h0,           lat: 2, miss: 1'b1, rdata: 32'hCAFE_0440};
        vecs[5]  = '{addr: 32'h0000_0040, wr: 1'b0, wdata: 32'h0,           lat: 1, miss: 1'b1, rdata: 32'h1234_5678};
        vecs[6]  = '{addr: 32'h0000_0044, wr: 1'b1, wdata: 32'hAAAA_5555,   lat: 1, miss: 1'b0, rdata: 32'h0};
        vecs[7]  = '{addr: 32'h0000_0044, wr: 1'b0, wdata: 32'h0,           lat: 2, miss: 1'b1, rdata: 32'hAAAA_5555};
        vecs[8]  = '{addr: 32'h0000_007C, wr: 1'b0, wdata: 32'h0,           lat: 4, miss: 1'b1, rdata: 32'hFFFF_FF83};
        vecs[9]  = '{addr: 32'h0000_007E, wr: 1'b0, wdata: 32'h0,           lat: 1, miss: 1'b0, rdata: 32'hFFFF_FF83};
        vecs[10] = '{addr: 32'hFFFF_FFC0, wr: 1'b0, wdata: 32'h0,           lat: 1, miss: 1'b1, rdata: 32'h0000_003F};
        vecs[11] = '{addr: 32'h0000_0440, wr: 1'b0, wdata: 32'h0,           lat: 2, miss: 1'b1, rdata: 32'hCAFE_0440};

        mem_model[32'h0000_0040] = 32'hDEAD_BEEF;
        mem_model[32'h0000_0440] = 32'hCAFE_0440;

        reset         = 1'b1;
        cache_address = '0;
        cache_read    = 1'b0;
        cache_write   = 1'b0;
        drive_en      = 1'b0;
        drive_val     = '0;
        mem_data_in   = '0;
        mem_ready     = 1'b0;

        #22;
        check("reset cache_hit", cache_hit, 0);
        check("reset mem_read", mem_read, 0);
        check("reset mem_write", mem_write, 0);
        check("reset mem_address", mem_address, 32'h0);
        check("reset mem_data_out", mem_data_out, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < 12; i++) do_req(i, vecs[i]);

        // Read and write together at 0x80: the store must go first, then the read misses.
        cache_address = 32'h0000_0080;
        cache_read    = 1'b1;
        cache_write   = 1'b1;
        drive_en      = 1'b1;
        drive_val     = 32'h8080_0001;
        run_until_hit(2, 32'h0000_0080, 1'b1, 32'h8080_0001, cyc, rd, wr);
        check("combo store cycles", cyc, 3);
        check("combo mem_write cycles", wr, 2);
        check("combo mem_read during store", rd, 0);
        cache_write = 1'b0;
        drive_en    = 1'b0;
        exp_q.push_back(32'h8080_0001);
        run_until_hit(1, 32'h0000_0080, 1'b0, 32'h0, cyc, rd, wr);
        check("combo read cycles", cyc, 3);
        check("combo read mem_read cycles", rd, 1);
        cache_read = 1'b0;

        // Reset two cycles into a fetch abandons it and clears all lines.
        cache_address = 32'h0000_0040;
        cache_read    = 1'b1;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        check("fetch in progress mem_read", mem_read, 1);
        check("fetch in progress mem_address", mem_address, 32'h0000_0040);
        #2;
        reset = 1'b1;
        #1;
        check("async reset mem_read", mem_read, 0);
        check("async reset mem_address", mem_address, 32'h0);
        check("async reset mem_data_out", mem_data_out, 32'h0);
        check("async reset cache_hit", cache_hit, 0);
        cache_read = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        do_req(20, '{addr: 32'h0000_0080, wr: 1'b0, wdata: 32'h0, lat: 1, miss: 1'b1, rdata: 32'h8080_0001});
        do_req(21, '{addr: 32'h0000_0040, wr: 1'b0, wdata: 32'h0, lat: 2, miss: 1'b1, rdata: 32'h1234_5678});

        check("scoreboard drained", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
